// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: writeback data select and load-type codes.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    WD_SEL_ALU  = 2'd0,
    WD_SEL_MEM  = 2'd1,
    WD_SEL_LINK = 2'd2
  } wd_sel_e;

  typedef enum logic [2:0] {
    LOAD_LW  = 3'd0,
    LOAD_LH  = 3'd1,
    LOAD_LHU = 3'd2,
    LOAD_LB  = 3'd3,
    LOAD_LBU = 3'd4
  } load_type_e;

endpackage

// File: rtl/wb_stage_load_ext.sv
// Little-endian byte/halfword extraction and sign/zero extension of a loaded word.
module load_ext
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rdata,
  input  logic [1:0]       addr_lo,
  input  logic [2:0]       load_type,
  output logic [WIDTH-1:0] ext_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte   = rdata[{addr_lo, 3'b000} +: 8];
    // addr_lo[0] is ignored for halfwords; misalignment traps before this point
    w_half   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    ext_data = rdata;
    case (load_type)
      LOAD_LB:  ext_data = {{(WIDTH-8){w_byte[7]}}, w_byte};
      LOAD_LBU: ext_data = {{(WIDTH-8){1'b0}}, w_byte};
      LOAD_LH:  ext_data = {{(WIDTH-16){w_half[15]}}, w_half};
      LOAD_LHU: ext_data = {{(WIDTH-16){1'b0}}, w_half};
      default:  ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback data selection for the five-stage MIPS core.
module wb_stage
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             m_valid,
  input  logic [WIDTH-1:0] m_pc,
  input  logic             m_reg_wen,
  input  logic [4:0]       m_wreg,
  input  logic [1:0]       m_wd_sel,
  input  logic [WIDTH-1:0] m_alu_result,
  input  logic [WIDTH-1:0] m_mem_rdata,
  input  logic [2:0]       m_load_type,
  output logic [WIDTH-1:0] w_pc,
  output logic [4:0]       w_wreg,
  output logic [WIDTH-1:0] w_wd,
  output logic             w_wen,
  output logic             w_fwd_valid,
  output logic [31:0]      w_instret
);

  logic             r_valid;
  logic [WIDTH-1:0] r_pc;
  logic             r_reg_wen;
  logic [4:0]       r_wreg;
  logic [1:0]       r_wd_sel;
  logic [WIDTH-1:0] r_alu_result;
  logic [WIDTH-1:0] r_mem_rdata;
  logic [2:0]       r_load_type;
  logic [31:0]      r_instret;

  logic [WIDTH-1:0] w_load_data;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_valid      <= 1'b0;
      r_pc         <= RESET_PC;
      r_reg_wen    <= 1'b0;
      r_wreg       <= '0;
      r_wd_sel     <= '0;
      r_alu_result <= '0;
      r_mem_rdata  <= '0;
      r_load_type  <= '0;
      // flush inserts a bubble but keeps the retired count
      if (reset) r_instret <= '0;
    end else if (!stall) begin
      r_valid      <= m_valid;
      r_pc         <= m_pc;
      r_reg_wen    <= m_reg_wen;
      r_wreg       <= m_wreg;
      r_wd_sel     <= m_wd_sel;
      r_alu_result <= m_alu_result;
      r_mem_rdata  <= m_mem_rdata;
      r_load_type  <= m_load_type;
      if (m_valid) r_instret <= r_instret + 32'd1;
    end
  end

  load_ext #(
    .WIDTH(WIDTH)
  ) u_load_ext (
    .rdata    (r_mem_rdata),
    .addr_lo  (r_alu_result[1:0]),
    .load_type(r_load_type),
    .ext_data (w_load_data)
  );

  always_comb begin
    w_wd = r_alu_result;
    case (r_wd_sel)
      WD_SEL_MEM:  w_wd = w_load_data;
      WD_SEL_LINK: w_wd = r_pc + WIDTH'(8);
      default:     w_wd = r_alu_result;
    endcase
  end

  assign w_pc        = r_pc;
  assign w_wreg      = r_wreg;
  assign w_wen       = r_valid & r_reg_wen;
  assign w_fwd_valid = w_wen & (r_wreg != 5'd0);
  assign w_instret   = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
module tb_wb_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_reg_wen;
  logic [4:0]  m_wreg;
  logic [1:0]  m_wd_sel;
  logic [31:0] m_alu_result;
  logic [31:0] m_mem_rdata;
  logic [2:0]  m_load_type;
  logic [31:0] w_pc;
  logic [4:0]  w_wreg;
  logic [31:0] w_wd;
  logic        w_wen;
  logic        w_fwd_valid;
  logic [31:0] w_instret;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_instret;

  wb_stage #(
    .WIDTH(32),
    .RESET_PC(32'h0000_3000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .m_valid     (m_valid),
    .m_pc        (m_pc),
    .m_reg_wen   (m_reg_wen),
    .m_wreg      (m_wreg),
    .m_wd_sel    (m_wd_sel),
    .m_alu_result(m_alu_result),
    .m_mem_rdata (m_mem_rdata),
    .m_load_type (m_load_type),
    .w_pc        (w_pc),
    .w_wreg      (w_wreg),
    .w_wd        (w_wd),
    .w_wen       (w_wen),
    .w_fwd_valid (w_fwd_valid),
    .w_instret   (w_instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] pc, input logic wen,
                       input logic [4:0] wreg, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [2:0] lt);
    m_valid = v; m_pc = pc; m_reg_wen = wen; m_wreg = wreg;
    m_wd_sel = sel; m_alu_result = alu; m_mem_rdata = rdata; m_load_type = lt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, $urandom, 1'b1, 5'($urandom), 2'($urandom), $urandom, $urandom, 3'($urandom));
      step();
    end
    exp_instret = 32'd0;
    checks++; if (w_wen !== 1'b0) begin failures++; $display("FAIL reset_wen got=%b exp=0", w_wen); end
    checks++; if (w_pc !== 32'h0000_3000) begin failures++; $display("FAIL reset_pc got=%h exp=00003000", w_pc); end
    checks++; if (w_wd !== 32'h0) begin failures++; $display("FAIL reset_wd got=%h exp=00000000", w_wd); end
    checks++; if (w_instret !== 32'd0) begin failures++; $display("FAIL reset_instret got=%0d exp=0", w_instret); end
    checks++; if (w_fwd_valid !== 1'b0) begin failures++; $display("FAIL reset_fwd got=%b exp=0", w_fwd_valid); end
    reset = 1'b0;
  endtask

  task automatic test_alu();
    drive(1'b1, 32'h0000_3004, 1'b1, 5'd8, 2'd0, 32'h1234_5678, 32'hFFFF_FFFF, 3'd0);
    step(); exp_instret = 32'd1;
    checks++; if (w_wen !== 1'b1) begin failures++; $display("FAIL alu_wen got=%b exp=1", w_wen); end
    checks++; if (w_wreg !== 5'd8) begin failures++; $display("FAIL alu_wreg got=%0d exp=8", w_wreg); end
    checks++; if (w_wd !== 32'h1234_5678) begin failures++; $display("FAIL alu_wd got=%h exp=12345678", w_wd); end
    checks++; if (w_instret !== exp_instret) begin failures++; $display("FAIL alu_instret got=%0d exp=%0d", w_instret, exp_instret); end
    checks++; if (w_fwd_valid !== 1'b1) begin failures++; $display("FAIL alu_fwd got=%b exp=1", w_fwd_valid); end
    checks++; if (w_pc !== 32'h0000_3004) begin failures++; $display("FAIL alu_pc got=%h exp=00003004", w_pc); end
    // sel=3 is reserved and behaves as ALU
    drive(1'b1, 32'h0000_3008, 1'b1, 5'd9, 2'd3, 32'hCAFE_0001, 32'h5555_5555, 3'd0);
    step(); exp_instret = 32'd2;
    checks++; if (w_wd !== 32'hCAFE_0001) begin failures++; $display("FAIL sel3_wd got=%h exp=cafe0001", w_wd); end
  endtask

  task automatic test_load_ext();
    logic [1:0]  lo [9]  = '{2'd3, 2'd2, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd3};
    logic [2:0]  lt [9]  = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd0, 3'd3, 3'd4, 3'd1, 3'd7};
    logic [31:0] ex [9]  = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_7F01,
                             32'h80FF_7F01, 32'h0000_0001, 32'h0000_007F, 32'h0000_7F01,
                             32'h80FF_7F01};
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 32'h0000_3100, 1'b1, 5'd10, 2'd1, {30'h0400_0000, lo[i]}, 32'h80FF_7F01, lt[i]);
      step(); exp_instret = exp_instret + 32'd1;
      checks++;
      if (w_wd !== ex[i]) begin
        failures++; $display("FAIL load_ext[%0d] type=%0d lo=%0d got=%h exp=%h", i, lt[i], lo[i], w_wd, ex[i]);
      end
    end
    // addr[0] ignored for halfword
    drive(1'b1, 32'h0000_3104, 1'b1, 5'd10, 2'd1, 32'h1000_0003, 32'h80FF_7F01, 3'd1);
    step(); exp_instret = exp_instret + 32'd1;
    checks++; if (w_wd !== 32'hFFFF_80FF) begin failures++; $display("FAIL lh_lo3 got=%h exp=ffff80ff", w_wd); end
    checks++; if (w_instret !== exp_instret) begin failures++; $display("FAIL load_instret got=%0d exp=%0d", w_instret, exp_instret); end
  endtask

  task automatic test_link();
    drive(1'b1, 32'h0000_3010, 1'b1, 5'd31, 2'd2, 32'h1111_1111, 32'h2222_2222, 3'd0);
    step(); exp_instret = exp_instret + 32'd1;
    checks++; if (w_wd !== 32'h0000_3018) begin failures++; $display("FAIL link_wd got=%h exp=00003018", w_wd); end
    checks++; if (w_wreg !== 5'd31) begin failures++; $display("FAIL link_wreg got=%0d exp=31", w_wreg); end
    drive(1'b1, 32'hFFFF_FFFC, 1'b1, 5'd31, 2'd2, 32'h1111_1111, 32'h2222_2222, 3'd0);
    step(); exp_instret = exp_instret + 32'd1;
    checks++; if (w_wd !== 32'h0000_0004) begin failures++; $display("FAIL link_wrap got=%h exp=00000004", w_wd); end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 32'h0000_3200, 1'b1, 5'd5, 2'd0, 32'hAAAA_5555, 32'h0, 3'd0);
    step(); exp_instret = exp_instret + 32'd1;
    // M changes between edges must not reach W outputs
    drive(1'b1, 32'h0000_3300, 1'b1, 5'd6, 2'd0, 32'h0BAD_0BAD, 32'h0, 3'd0);
    #2;
    checks++; if (w_wd !== 32'hAAAA_5555) begin failures++; $display("FAIL no_comb_path got=%h exp=aaaa5555", w_wd); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0000_3300 + 32'(i), 1'b1, 5'(6 + i), 2'd2, 32'h0BAD_0000 + 32'(i), 32'h0, 3'd0);
      step();
      checks++;
      if (w_wd !== 32'hAAAA_5555 || w_wreg !== 5'd5 || w_pc !== 32'h0000_3200 || w_instret !== exp_instret) begin
        failures++;
        $display("FAIL stall[%0d] wd=%h wreg=%0d pc=%h instret=%0d exp wd=aaaa5555 wreg=5 pc=00003200 instret=%0d",
                 i, w_wd, w_wreg, w_pc, w_instret, exp_instret);
      end
    end
    flush = 1'b1;
    step();
    checks++; if (w_wen !== 1'b0) begin failures++; $display("FAIL flush_wen got=%b exp=0", w_wen); end
    checks++; if (w_pc !== 32'h0000_3000) begin failures++; $display("FAIL flush_pc got=%h exp=00003000", w_pc); end
    checks++; if (w_instret !== exp_instret) begin failures++; $display("FAIL flush_instret got=%0d exp=%0d", w_instret, exp_instret); end
    stall = 1'b0; flush = 1'b0;
    // invalid instruction: no write, no retire
    drive(1'b0, 32'h0000_3400, 1'b1, 5'd7, 2'd0, 32'h7777_7777, 32'h0, 3'd0);
    step();
    checks++; if (w_wen !== 1'b0 || w_instret !== exp_instret) begin
      failures++; $display("FAIL bubble_in wen=%b instret=%0d exp wen=0 instret=%0d", w_wen, w_instret, exp_instret);
    end
  endtask

  task automatic test_zero_reg();
    drive(1'b1, 32'h0000_3500, 1'b1, 5'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 3'd0);
    step(); exp_instret = exp_instret + 32'd1;
    checks++; if (w_wen !== 1'b1) begin failures++; $display("FAIL zero_wen got=%b exp=1", w_wen); end
    checks++; if (w_wd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL zero_wd got=%h exp=deadbeef", w_wd); end
    checks++; if (w_fwd_valid !== 1'b0) begin failures++; $display("FAIL zero_fwd got=%b exp=0", w_fwd_valid); end
  endtask

  task automatic test_back_to_back_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0000_3600 + 32'(4 * i), 1'b1, 5'(i + 1), 2'd0, 32'(i * 3), 32'h0, 3'd0);
      step(); exp_instret = exp_instret + 32'd1;
    end
    checks++; if (w_instret !== exp_instret) begin failures++; $display("FAIL b2b_instret got=%0d exp=%0d", w_instret, exp_instret); end
    checks++; if (w_wd !== 32'd9) begin failures++; $display("FAIL b2b_wd got=%h exp=00000009", w_wd); end
    reset = 1'b1;
    step(); exp_instret = 32'd0;
    checks++; if (w_instret !== 32'd0 || w_wen !== 1'b0) begin
      failures++; $display("FAIL midreset instret=%0d wen=%b exp instret=0 wen=0", w_instret, w_wen);
    end
    reset = 1'b0;
    step(); exp_instret = 32'd1;
    checks++; if (w_instret !== exp_instret) begin failures++; $display("FAIL post_reset_instret got=%0d exp=1", w_instret); end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 3'd0);
    exp_instret = 32'd0;
    test_reset();
    test_alu();
    test_load_ext();
    test_link();
    test_stall_flush();
    test_zero_reg();
    test_back_to_back_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
